// File: rtl/one_port_mem_arbiter_2048_8_if.sv
// Client-side bundle for the two-port arbiter: request/ready handshake and read responses.
// The client drives the master side; the arbiter implements the slave side.
interface one_port_mem_arbiter_2048_8_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata
    );
endinterface

// File: rtl/one_port_mem_arbiter_2048_8.sv
// Shares one single-port 2048x8 macro between two clients: clears it after reset,
// then grants one access per cycle (round-robin or fixed priority) and steers read data back.
module one_port_mem_arbiter_2048_8 #(
    parameter int              ADDR_W     = 11,
    parameter int              DATA_W     = 8,
    parameter int              INIT_EN    = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE = 8'h00,
    parameter int              FIXED_PRI  = 0
) (
    input  logic              CLK,
    input  logic              RST,
    one_port_mem_arbiter_2048_8_if.slave bus,
    output logic              init_done,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_D,
    output logic              mem_CEN,
    output logic              mem_WEN,
    output logic              mem_OEN,
    input  logic [DATA_W-1:0] mem_Q
);
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] clr_addr_reg;
    logic              last_reg;      // 1 = port 1 was granted most recently
    logic [ADDR_W-1:0] mem_a_reg;
    logic [DATA_W-1:0] mem_d_reg;

    logic [1:0]        req_valid;
    logic [1:0]        req_we;
    logic [ADDR_W-1:0] req_addr [2];
    logic [DATA_W-1:0] req_wdata [2];
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_rdata [2];

    logic              run_en;
    logic              clr_en;
    logic              tie_to_0;
    logic [1:0]        grant;
    logic              win;
    logic              access;
    logic [ADDR_W-1:0] acc_a;
    logic [DATA_W-1:0] acc_d;

    always_comb begin
        req_valid    = {bus.req1_valid, bus.req0_valid};
        req_we       = {bus.req1_we, bus.req0_we};
        req_addr[0]  = bus.req0_addr;
        req_addr[1]  = bus.req1_addr;
        req_wdata[0] = bus.req0_wdata;
        req_wdata[1] = bus.req1_wdata;
    end

    // RST gates pins combinationally so nothing reaches the macro while reset is held.
    always_comb begin
        run_en   = ~RST & ((state_reg == ST_RUN) | (INIT_EN == 0));
        clr_en   = ~RST & (state_reg == ST_INIT) & (INIT_EN != 0);
        tie_to_0 = (FIXED_PRI != 0) | last_reg;
        grant    = 2'b00;
        if (run_en) begin
            if (req_valid[0] && (!req_valid[1] || tie_to_0)) begin
                grant = 2'b01;
            end else if (req_valid[1]) begin
                grant = 2'b10;
            end
        end
        win    = grant[1];
        access = clr_en | (|grant);
        acc_a  = clr_en ? clr_addr_reg : req_addr[win];
        acc_d  = clr_en ? INIT_VALUE : req_wdata[win];
    end

    assign mem_A     = access ? acc_a : mem_a_reg;
    assign mem_D     = access ? acc_d : mem_d_reg;
    assign mem_CEN   = ~access;
    assign mem_WEN   = clr_en ? 1'b0 : ((|grant) ? ~req_we[win] : 1'b1);
    assign mem_OEN   = 1'b0;
    assign init_done = run_en;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= ST_INIT;
            clr_addr_reg <= '0;
            last_reg     <= 1'b1;
            mem_a_reg    <= '0;
            mem_d_reg    <= '0;
        end else begin
            if (access) begin
                mem_a_reg <= acc_a;
                mem_d_reg <= acc_d;
            end
            if (clr_en) begin
                clr_addr_reg <= clr_addr_reg + 1'b1;
                if (clr_addr_reg == '1) begin
                    state_reg <= ST_RUN;
                end
            end
            if (INIT_EN == 0) begin
                state_reg <= ST_RUN;
            end
            if (|grant) begin
                last_reg <= win;
            end
        end
    end

    // The macro registers Q, so a read granted now is answered next cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        logic rd_port_reg;
        always_ff @(posedge CLK) begin
            if (RST) begin
                rd_port_reg <= 1'b0;
            end else begin
                rd_port_reg <= grant[gi] & ~req_we[gi];
            end
        end
        assign rsp_valid[gi] = rd_port_reg & ~RST;
        assign rsp_rdata[gi] = rsp_valid[gi] ? mem_Q : '0;
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.rsp0_valid = rsp_valid[0];
    assign bus.rsp1_valid = rsp_valid[1];
    assign bus.rsp0_rdata = rsp_rdata[0];
    assign bus.rsp1_rdata = rsp_rdata[1];
endmodule

// File: tb/tb_one_port_mem_arbiter_2048_8.sv
// Bench: DUT a (clear to A5, round-robin) against a transaction-level model with random traffic;
// DUT b (no clear, fixed priority) with directed priority and reset-suppression checks.
module tb_one_port_mem_arbiter_2048_8;
    localparam int AW = 11;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic done_a, done_b;
    logic [AW-1:0] a_A, b_A;
    logic [DW-1:0] a_D, b_D, a_Q, b_Q;
    logic a_CEN, a_WEN, a_OEN, b_CEN, b_WEN, b_OEN;

    one_port_mem_arbiter_2048_8_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    one_port_mem_arbiter_2048_8_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

    one_port_mem_arbiter_2048_8 #(.ADDR_W(AW), .DATA_W(DW), .INIT_EN(1),
        .INIT_VALUE(8'hA5), .FIXED_PRI(0)) dut_a (
        .CLK(clk), .RST(rst_a), .bus(ifa), .init_done(done_a),
        .mem_A(a_A), .mem_D(a_D), .mem_CEN(a_CEN), .mem_WEN(a_WEN), .mem_OEN(a_OEN), .mem_Q(a_Q));

    one_port_mem_arbiter_2048_8 #(.ADDR_W(AW), .DATA_W(DW), .INIT_EN(0),
        .INIT_VALUE(8'h00), .FIXED_PRI(1)) dut_b (
        .CLK(clk), .RST(rst_b), .bus(ifb), .init_done(done_b),
        .mem_A(b_A), .mem_D(b_D), .mem_CEN(b_CEN), .mem_WEN(b_WEN), .mem_OEN(b_OEN), .mem_Q(b_Q));

    // Behavioural single-port macros with registered Q.
    logic [DW-1:0] macro_a [0:2047];
    logic [DW-1:0] macro_b [0:2047];
    always @(posedge clk) begin
        if (!a_CEN) begin
            if (!a_WEN) macro_a[a_A] <= a_D;
            else        a_Q <= macro_a[a_A];
        end
        if (!b_CEN) begin
            if (!b_WEN) macro_b[b_A] <= b_D;
            else        b_Q <= macro_b[b_A];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag, input logic r0, input logic r1,
                               input logic v0, input logic v1, input logic [DW-1:0] d0,
                               input logic [DW-1:0] d1, input logic dn, input logic cen,
                               input logic wen, input logic oen, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
        check({tag, "_ready0"}, r0, 0);
        check({tag, "_ready1"}, r1, 0);
        check({tag, "_rsp0_valid"}, v0, 0);
        check({tag, "_rsp1_valid"}, v1, 0);
        check({tag, "_rsp0_rdata"}, d0, 0);
        check({tag, "_rsp1_rdata"}, d1, 0);
        check({tag, "_init_done"}, dn, 0);
        check({tag, "_CEN"}, cen, 1);
        check({tag, "_WEN"}, wen, 1);
        check({tag, "_OEN"}, oen, 0);
        check({tag, "_A"}, a, 0);
        check({tag, "_D"}, d, 0);
    endtask

    task automatic set_a(input int p, input logic v, input logic we,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        if (p == 0) begin
            ifa.req0_valid = v; ifa.req0_we = we; ifa.req0_addr = ad; ifa.req0_wdata = wd;
        end else begin
            ifa.req1_valid = v; ifa.req1_we = we; ifa.req1_addr = ad; ifa.req1_wdata = wd;
        end
    endtask

    task automatic set_b(input int p, input logic v, input logic we,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        if (p == 0) begin
            ifb.req0_valid = v; ifb.req0_we = we; ifb.req0_addr = ad; ifb.req0_wdata = wd;
        end else begin
            ifb.req1_valid = v; ifb.req1_we = we; ifb.req1_addr = ad; ifb.req1_wdata = wd;
        end
    endtask

    // Reference model for DUT a: memory image, last winner, pending responses, held pins.
    logic [DW-1:0] ref_mem [0:2047];
    int            last_win;
    logic          exp_v [2];
    logic [DW-1:0] exp_d [2];
    logic [AW-1:0] hold_a;
    logic [DW-1:0] hold_d;

    task automatic run_cycle_a(output logic [1:0] g);
        int w;
        logic we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        @(negedge clk);
        check("rsp0_valid", ifa.rsp0_valid, exp_v[0]);
        check("rsp0_rdata", ifa.rsp0_rdata, exp_v[0] ? exp_d[0] : 8'h00);
        check("rsp1_valid", ifa.rsp1_valid, exp_v[1]);
        check("rsp1_rdata", ifa.rsp1_rdata, exp_v[1] ? exp_d[1] : 8'h00);
        check("init_done_run", done_a, 1);
        check("OEN_run", a_OEN, 0);
        if (ifa.req0_valid && ifa.req1_valid) w = (last_win == 0) ? 1 : 0;
        else if (ifa.req0_valid)              w = 0;
        else if (ifa.req1_valid)              w = 1;
        else                                  w = -1;
        check("ready0", ifa.req0_ready, w == 0);
        check("ready1", ifa.req1_ready, w == 1);
        g = 2'b00;
        exp_v[0] = 1'b0;
        exp_v[1] = 1'b0;
        if (w >= 0) begin
            we = (w == 0) ? ifa.req0_we : ifa.req1_we;
            ad = (w == 0) ? ifa.req0_addr : ifa.req1_addr;
            wd = (w == 0) ? ifa.req0_wdata : ifa.req1_wdata;
            check("CEN_grant", a_CEN, 0);
            check("WEN_grant", a_WEN, !we);
            check("A_grant", a_A, ad);
            check("D_grant", a_D, wd);
            if (!we) begin
                exp_v[w] = 1'b1;
                exp_d[w] = ref_mem[ad];
            end else begin
                ref_mem[ad] = wd;
            end
            last_win = w;
            hold_a = ad;
            hold_d = wd;
            g[w] = 1'b1;
        end else begin
            check("CEN_idle", a_CEN, 1);
            check("WEN_idle", a_WEN, 1);
            check("A_hold", a_A, hold_a);
            check("D_hold", a_D, hold_d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] g;
        logic pend [2];
        int rdy_seen, clr_bad, done_bad;
        logic [AW-1:0] rd_addrs [3];

        rst_a = 1'b1;
        rst_b = 1'b1;
        set_a(0, 0, 0, 0, 0); set_a(1, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0); set_b(1, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset("rst_a", ifa.req0_ready, ifa.req1_ready, ifa.rsp0_valid, ifa.rsp1_valid,
                    ifa.rsp0_rdata, ifa.rsp1_rdata, done_a, a_CEN, a_WEN, a_OEN, a_A, a_D);
        check_reset("rst_b", ifb.req0_ready, ifb.req1_ready, ifb.rsp0_valid, ifb.rsp1_valid,
                    ifb.rsp0_rdata, ifb.rsp1_rdata, done_b, b_CEN, b_WEN, b_OEN, b_A, b_D);
        @(posedge clk);
        #1;

        // Clear aborted at address 700 by a one-cycle reset; port 0 probes for ready throughout.
        rst_a = 1'b0;
        set_a(0, 1, 0, 11'd0, 8'h00);
        rdy_seen = 0;
        clr_bad = 0;
        done_bad = 0;
        for (int k = 0; k < 700; k++) begin
            @(negedge clk);
            if (ifa.req0_ready || ifa.req1_ready) rdy_seen++;
            if (a_CEN !== 1'b0 || a_WEN !== 1'b0 || a_A !== AW'(k) || a_D !== 8'hA5) clr_bad++;
            if (done_a !== 1'b0) done_bad++;
            @(posedge clk);
            #1;
        end
        rst_a = 1'b1;
        @(negedge clk);
        check("CEN_in_midclear_rst", a_CEN, 1);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        for (int k = 0; k < 2048; k++) begin
            @(negedge clk);
            if (ifa.req0_ready || ifa.req1_ready) rdy_seen++;
            if (a_CEN !== 1'b0 || a_WEN !== 1'b0 || a_A !== AW'(k) || a_D !== 8'hA5) clr_bad++;
            if (done_a !== 1'b0) done_bad++;
            @(posedge clk);
            #1;
        end
        check("clear_pin_bad_cycles", clr_bad, 0);
        check("ready_during_init", rdy_seen, 0);
        check("init_done_early", done_bad, 0);
        set_a(0, 0, 0, 0, 0);

        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'hA5;
        last_win = 1;
        exp_v[0] = 1'b0; exp_v[1] = 1'b0;
        exp_d[0] = 8'h00; exp_d[1] = 8'h00;
        hold_a = 11'd2047;
        hold_d = 8'hA5;

        // Cycle 2048: first RUN cycle, idle.
        run_cycle_a(g);

        rd_addrs[0] = 11'd0; rd_addrs[1] = 11'd1023; rd_addrs[2] = 11'd2047;
        for (int i = 0; i < 3; i++) begin
            set_a(0, 1, 0, rd_addrs[i], 8'h00);
            run_cycle_a(g);
            set_a(0, 0, 0, 0, 0);
            run_cycle_a(g);
        end

        // Write then immediate read of the same address.
        set_a(0, 1, 1, 11'd5, 8'h3C);
        run_cycle_a(g);
        set_a(0, 1, 0, 11'd5, 8'h00);
        run_cycle_a(g);
        set_a(0, 0, 0, 0, 0);
        run_cycle_a(g);

        // Round-robin: seed 10/20, last winner port 1, then both read continuously.
        set_a(0, 1, 1, 11'd10, 8'h11);
        run_cycle_a(g);
        set_a(0, 0, 0, 0, 0);
        set_a(1, 1, 1, 11'd20, 8'h22);
        run_cycle_a(g);
        set_a(0, 1, 0, 11'd10, 8'h00);
        set_a(1, 1, 0, 11'd20, 8'h00);
        for (int i = 0; i < 8; i++) begin
            run_cycle_a(g);
            check("rr_alternate", g, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        set_a(0, 0, 0, 0, 0); set_a(1, 0, 0, 0, 0);
        run_cycle_a(g);

        // Random traffic; a request stays stable until granted.
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        set_a(p, 1, 1'($urandom_range(0, 1)),
                              ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 15))
                                                          : AW'($urandom_range(0, 2047)),
                              DW'($urandom_range(0, 255)));
                        pend[p] = 1'b1;
                    end else begin
                        set_a(p, 0, 0, 0, 0);
                    end
                end
            end
            run_cycle_a(g);
            if (g[0]) pend[0] = 1'b0;
            if (g[1]) pend[1] = 1'b0;
        end
        set_a(0, 0, 0, 0, 0); set_a(1, 0, 0, 0, 0);
        run_cycle_a(g);

        // DUT b: no clear, fixed priority.
        @(negedge clk);
        check("b_done_in_rst", done_b, 0);
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        @(negedge clk);
        check("b_done_cycle0", done_b, 1);
        check("b_CEN_cycle0", b_CEN, 1);
        set_b(1, 1, 1, 11'd3, 8'h77);
        @(negedge clk);
        check("b_wr_ready1", ifb.req1_ready, 1);
        check("b_wr_WEN", b_WEN, 0);
        @(posedge clk);
        #1;
        set_b(0, 1, 0, 11'd3, 8'h00);
        set_b(1, 1, 0, 11'd3, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fp_ready0", ifb.req0_ready, 1);
            check("fp_ready1", ifb.req1_ready, 0);
            if (i > 0) begin
                check("fp_rsp0_valid", ifb.rsp0_valid, 1);
                check("fp_rsp0_rdata", ifb.rsp0_rdata, 8'h77);
            end
            @(posedge clk);
            #1;
        end
        set_b(0, 0, 0, 0, 0);
        @(negedge clk);
        check("fp_port1_after_drop", ifb.req1_ready, 1);
        check("fp_port1_WEN", b_WEN, 1);
        @(posedge clk);
        #1;
        // Reset lands in the cycle that would carry port 1's response.
        rst_b = 1'b1;
        set_b(1, 0, 0, 0, 0);
        @(negedge clk);
        check("supp_rsp1_valid", ifb.rsp1_valid, 0);
        check("supp_rsp1_rdata", ifb.rsp1_rdata, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset("rst_b2", ifb.req0_ready, ifb.req1_ready, ifb.rsp0_valid, ifb.rsp1_valid,
                    ifb.rsp0_rdata, ifb.rsp1_rdata, done_b, b_CEN, b_WEN, b_OEN, b_A, b_D);
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("supp_rsp1_after", ifb.rsp1_valid, 0);
            check("supp_done_after", done_b, 1);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
